// File: rtl/id_pkg.sv
// Shared constants for the decode-stage operand front end.
// Instruction field positions, stall bus bits and register-zero id.
package id_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int STALL_IF_BIT = 1;
  localparam int STALL_ID_BIT = 2;

  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;

  localparam logic [31:0] NOP_INST = 32'h0;

endpackage

// File: rtl/id_operand_front_if.sv
// Bus bundle between IF/SRAM/producers and the ID operand front end.
// stall_cycles exists only when ID_PERF_CNT_EN is defined.
interface id_operand_front_if #(
  parameter int NUM_FWD = 2,
  parameter int STALL_W = 6
);
  logic [STALL_W-1:0]   stall;
  logic                 flush;
  logic                 if_ce;
  logic [31:0]          if_pc;
  logic [31:0]          inst_sram_rdata;
  logic [NUM_FWD-1:0]   fwd_we;
  logic [5*NUM_FWD-1:0] fwd_waddr;
  logic [32*NUM_FWD-1:0] fwd_wdata;
  logic [NUM_FWD-1:0]   fwd_is_load;
  logic [4:0]           rf_raddr1;
  logic [4:0]           rf_raddr2;
  logic [31:0]          rf_rdata1;
  logic [31:0]          rf_rdata2;
  logic                 id_valid;
  logic [31:0]          id_pc;
  logic [31:0]          id_inst;
  logic [31:0]          src1;
  logic [31:0]          src2;
  logic                 stallreq;
`ifdef ID_PERF_CNT_EN
  logic [31:0]          stall_cycles;
`endif

  modport slave (
`ifdef ID_PERF_CNT_EN
    output stall_cycles,
`endif
    input  stall, flush, if_ce, if_pc,
    input  inst_sram_rdata,
    input  fwd_we, fwd_waddr, fwd_wdata,
    input  fwd_is_load,
    input  rf_rdata1, rf_rdata2,
    output rf_raddr1, rf_raddr2,
    output id_valid, id_pc, id_inst,
    output src1, src2, stallreq
  );

  modport master (
`ifdef ID_PERF_CNT_EN
    input  stall_cycles,
`endif
    output stall, flush, if_ce, if_pc,
    output inst_sram_rdata,
    output fwd_we, fwd_waddr, fwd_wdata,
    output fwd_is_load,
    output rf_rdata1, rf_rdata2,
    input  rf_raddr1, rf_raddr2,
    input  id_valid, id_pc, id_inst,
    input  src1, src2, stallreq
  );

endinterface

// File: rtl/id_fwd_mux.sv
// One-operand forwarding resolver; producer 0 is youngest and wins.
// Register zero always reads 0 and never raises a load hit.
module id_fwd_mux
  import id_pkg::*;
#(
  parameter int NUM_FWD = 2
) (
  input  logic [4:0]            addr,
  input  logic [NUM_FWD-1:0]    fwd_we,
  input  logic [5*NUM_FWD-1:0]  fwd_waddr,
  input  logic [32*NUM_FWD-1:0] fwd_wdata,
  input  logic [NUM_FWD-1:0]    fwd_is_load,
  input  logic [31:0]           rf_rdata,
  output logic [31:0]           value,
  output logic                  load_hit
);

  // Scan oldest to youngest so the lowest matching index is last to write
  always_comb begin
    value    = rf_rdata;
    load_hit = 1'b0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_we[i] && (fwd_waddr[5*i +: 5] == addr)) begin
        value    = fwd_wdata[32*i +: 32];
        load_hit = fwd_is_load[i];
      end
    end
    if (addr == REG_ZERO) begin
      value    = '0;
      load_hit = 1'b0;
    end
  end

endmodule

// File: rtl/id_operand_front.sv
// IF->ID register, stall hold buffer, forwarding and load-use interlock.
// Optional stall cycle counter enabled by defining ID_PERF_CNT_EN.
module id_operand_front
  import id_pkg::*;
#(
  parameter int NUM_FWD = 2,
  parameter int STALL_W = 6
) (
  input logic clk,
  input logic rst,
  id_operand_front_if.slave bus
);

  logic        id_valid_q;
  logic [31:0] id_pc_q;
  logic        hold_valid;
  logic [31:0] hold_inst;
  logic [31:0] inst;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        hit1;
  logic        hit2;
  logic        if_stop;
  logic        id_stop;
  logic        unused_stall;

  assign if_stop = bus.stall[STALL_IF_BIT];
  assign id_stop = bus.stall[STALL_ID_BIT];
  assign unused_stall = ^bus.stall;

  // ID slot advance / bubble / hold, flush has priority over stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      hold_valid <= 1'b0;
      hold_inst  <= '0;
    end else if (bus.flush) begin
      id_valid_q <= 1'b0;
      hold_valid <= 1'b0;
    end else if (if_stop && !id_stop) begin
      id_valid_q <= 1'b0;
      hold_valid <= 1'b0;
    end else if (!if_stop) begin
      id_valid_q <= bus.if_ce;
      id_pc_q    <= bus.if_pc;
      hold_valid <= 1'b0;
    end else if (!hold_valid) begin
      hold_inst  <= bus.inst_sram_rdata;
      hold_valid <= 1'b1;
    end
  end

  assign inst = !id_valid_q ? NOP_INST :
                hold_valid  ? hold_inst :
                              bus.inst_sram_rdata;

  assign rs = inst[RS_HI:RS_LO];
  assign rt = inst[RT_HI:RT_LO];

  assign bus.id_valid  = id_valid_q;
  assign bus.id_pc     = id_pc_q;
  assign bus.id_inst   = inst;
  assign bus.rf_raddr1 = rs;
  assign bus.rf_raddr2 = rt;

  id_fwd_mux #(.NUM_FWD(NUM_FWD)) u_fwd_rs (
    .addr        (rs),
    .fwd_we      (bus.fwd_we),
    .fwd_waddr   (bus.fwd_waddr),
    .fwd_wdata   (bus.fwd_wdata),
    .fwd_is_load (bus.fwd_is_load),
    .rf_rdata    (bus.rf_rdata1),
    .value       (bus.src1),
    .load_hit    (hit1)
  );

  id_fwd_mux #(.NUM_FWD(NUM_FWD)) u_fwd_rt (
    .addr        (rt),
    .fwd_we      (bus.fwd_we),
    .fwd_waddr   (bus.fwd_waddr),
    .fwd_wdata   (bus.fwd_wdata),
    .fwd_is_load (bus.fwd_is_load),
    .rf_rdata    (bus.rf_rdata2),
    .value       (bus.src2),
    .load_hit    (hit2)
  );

  assign bus.stallreq = id_valid_q & (hit1 | hit2);

`ifdef ID_PERF_CNT_EN
  logic [31:0] stall_cnt;

  // Saturating count of interlocked cycles, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (id_valid_q && bus.stallreq && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign bus.stall_cycles = stall_cnt;
`endif

endmodule

// File: tb/tb_id_operand_front.sv
// Directed plus random test of id_operand_front against a reference model.
// Model tracks the ID slot as "shown word" and resolves operands by search.
module tb_id_operand_front;

  localparam int NF = 2;
  localparam int SW = 6;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  id_operand_front_if #(.NUM_FWD(NF), .STALL_W(SW)) bus ();

  id_operand_front #(.NUM_FWD(NF), .STALL_W(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  bit          m_valid;
  logic [31:0] m_pc;
  bit          m_frozen;
  logic [31:0] m_word;
  logic [31:0] m_cnt;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_inst();
    if (!m_valid) return 32'h0;
    if (m_frozen) return m_word;
    return bus.inst_sram_rdata;
  endfunction

  function automatic void resolve(input logic [4:0] a,
                                  input logic [31:0] rf,
                                  output logic [31:0] v,
                                  output bit ld);
    v  = rf;
    ld = 1'b0;
    if (a == 5'd0) begin
      v = 32'h0;
      return;
    end
    for (int i = 0; i < NF; i++) begin
      if (bus.fwd_we[i] && bus.fwd_waddr[5*i +: 5] == a) begin
        v  = bus.fwd_wdata[32*i +: 32];
        ld = bus.fwd_is_load[i];
        return;
      end
    end
  endfunction

  task automatic m_reset();
    m_valid  = 1'b0;
    m_pc     = '0;
    m_frozen = 1'b0;
    m_word   = '0;
    m_cnt    = '0;
  endtask

  task automatic check_all(string tag);
    logic [31:0] ei, s1, s2;
    bit l1, l2;
    #1;
    ei = m_inst();
    resolve(ei[25:21], bus.rf_rdata1, s1, l1);
    resolve(ei[20:16], bus.rf_rdata2, s2, l2);
    chk({tag, "_valid"}, 32'(bus.id_valid), 32'(m_valid));
    chk({tag, "_pc"}, bus.id_pc, m_pc);
    chk({tag, "_inst"}, bus.id_inst, ei);
    chk({tag, "_ra1"}, 32'(bus.rf_raddr1), 32'(ei[25:21]));
    chk({tag, "_ra2"}, 32'(bus.rf_raddr2), 32'(ei[20:16]));
    chk({tag, "_sreq"}, 32'(bus.stallreq), 32'(m_valid && (l1 || l2)));
    if (m_valid) begin
      chk({tag, "_src1"}, bus.src1, s1);
      chk({tag, "_src2"}, bus.src2, s2);
    end
`ifdef ID_PERF_CNT_EN
    chk({tag, "_cnt"}, bus.stall_cycles, m_cnt);
`endif
  endtask

  task automatic tick();
    logic [31:0] ei, v;
    bit l1, l2, sr;
    logic [SW-1:0] st;
    ei = m_inst();
    resolve(ei[25:21], bus.rf_rdata1, v, l1);
    resolve(ei[20:16], bus.rf_rdata2, v, l2);
    sr = m_valid && (l1 || l2);
    st = bus.stall;
    @(posedge clk);
    if (sr && m_cnt != 32'hFFFF_FFFF) m_cnt++;
    if (bus.flush) begin
      m_valid  = 1'b0;
      m_frozen = 1'b0;
    end else if (st[1] && !st[2]) begin
      m_valid  = 1'b0;
      m_frozen = 1'b0;
    end else if (!st[1]) begin
      m_valid  = bus.if_ce;
      m_pc     = bus.if_pc;
      m_frozen = 1'b0;
    end else if (!m_frozen) begin
      m_word   = bus.inst_sram_rdata;
      m_frozen = 1'b1;
    end
    #1;
  endtask

  task automatic fwd_off();
    bus.fwd_we      = '0;
    bus.fwd_waddr   = '0;
    bus.fwd_wdata   = '0;
    bus.fwd_is_load = '0;
  endtask

  task automatic randomize_inputs();
    logic [31:0] w;
    case ($urandom_range(0, 3))
      0: bus.stall = 6'b000000;
      1: bus.stall = 6'b000110;
      2: bus.stall = 6'b000010;
      default: bus.stall = 6'($urandom);
    endcase
    bus.flush = ($urandom_range(0, 15) == 0);
    bus.if_ce = ($urandom_range(0, 5) != 0);
    bus.if_pc = $urandom;
    w = $urandom;
    w[25:21] = 5'($urandom_range(0, 7));
    w[20:16] = 5'($urandom_range(0, 7));
    bus.inst_sram_rdata = w;
    for (int i = 0; i < NF; i++) begin
      bus.fwd_we[i] = 1'($urandom);
      bus.fwd_waddr[5*i +: 5] = 5'($urandom_range(0, 7));
      bus.fwd_wdata[32*i +: 32] = $urandom;
      bus.fwd_is_load[i] = ($urandom_range(0, 3) == 0);
    end
    bus.rf_rdata1 = $urandom;
    bus.rf_rdata2 = $urandom;
  endtask

  logic [31:0] c0;

  initial begin
    rst = 1'b1;
    bus.stall = '0;
    bus.flush = 1'b0;
    bus.if_ce = 1'b0;
    bus.if_pc = '0;
    bus.inst_sram_rdata = '0;
    bus.rf_rdata1 = 32'h1234;
    bus.rf_rdata2 = 32'h5678;
    fwd_off();
    m_reset();
    check_all("rst");
    chk("rst_valid0", 32'(bus.id_valid), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    bus.if_ce = 1'b1;
    bus.if_pc = 32'hBFC0_0000;
    check_all("boot0");
    tick();
    bus.inst_sram_rdata = 32'h1111;
    check_all("boot1");
    chk("tp_pc", bus.id_pc, 32'hBFC0_0000);
    chk("tp_inst", bus.id_inst, 32'h1111);

    bus.stall = 6'b000110;
    check_all("hold0");
    tick();
    bus.inst_sram_rdata = 32'h2222;
    check_all("hold1");
    chk("tp_hold1", bus.id_inst, 32'h1111);
    tick();
    bus.inst_sram_rdata = 32'h3333;
    check_all("hold2");
    chk("tp_hold2", bus.id_inst, 32'h1111);
    tick();
    bus.stall = '0;
    bus.if_pc = 32'hBFC0_0004;
    bus.inst_sram_rdata = 32'h4444;
    check_all("rel0");
    chk("tp_rel0", bus.id_inst, 32'h1111);
    tick();
    check_all("rel1");
    chk("tp_rel1", bus.id_inst, 32'h4444);

    bus.inst_sram_rdata = 32'h00A0_0000;
    tick();
    bus.fwd_we    = 2'b11;
    bus.fwd_waddr = {5'd5, 5'd5};
    bus.fwd_wdata = {32'hB, 32'hA};
    check_all("fwd2");
    chk("tp_fwd0", bus.src1, 32'hA);
    bus.fwd_we = 2'b10;
    check_all("fwd1");
    chk("tp_fwd1", bus.src1, 32'hB);
    bus.fwd_we = 2'b00;
    check_all("fwdn");
    chk("tp_rf", bus.src1, 32'h1234);

    bus.fwd_we      = 2'b01;
    bus.fwd_waddr   = '0;
    bus.fwd_wdata   = {32'h0, 32'hDEAD};
    bus.fwd_is_load = 2'b01;
    check_all("rz");
    chk("tp_rz_src2", bus.src2, 32'h0);
    chk("tp_rz_sreq", 32'(bus.stallreq), 32'h0);

    fwd_off();
    bus.inst_sram_rdata = 32'h00E0_0000;
    tick();
    bus.fwd_we      = 2'b01;
    bus.fwd_waddr   = {5'd0, 5'd7};
    bus.fwd_is_load = 2'b01;
    check_all("lu");
    chk("tp_lu", 32'(bus.stallreq), 32'h1);
    c0 = m_cnt;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_all("lu_n");
    end
`ifdef ID_PERF_CNT_EN
    chk("tp_cnt4", bus.stall_cycles, c0 + 32'd4);
`endif
    bus.fwd_we      = 2'b11;
    bus.fwd_waddr   = {5'd7, 5'd7};
    bus.fwd_is_load = 2'b10;
    check_all("shadow");
    chk("tp_shadow", 32'(bus.stallreq), 32'h0);
    fwd_off();

    bus.inst_sram_rdata = 32'h5555;
    tick();
    bus.stall = 6'b000110;
    tick();
    tick();
    bus.inst_sram_rdata = 32'h6666;
    check_all("fh0");
    chk("tp_fh0", bus.id_inst, 32'h5555);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.stall = '0;
    check_all("fh1");
    chk("tp_fh_valid", 32'(bus.id_valid), 32'h0);
    chk("tp_fh_inst", bus.id_inst, 32'h0);
    tick();
    bus.inst_sram_rdata = 32'h7777;
    check_all("fh2");
    chk("tp_fh_new", bus.id_inst, 32'h7777);

    for (int n = 0; n < 400; n++) begin
      randomize_inputs();
      check_all("rnd");
      tick();
    end

    bus.stall = '0;
    bus.flush = 1'b0;
    bus.if_ce = 1'b1;
    bus.if_pc = 32'h8000_0000;
    tick();
    check_all("prerst");
    #2;
    rst = 1'b1;
    m_reset();
    check_all("midrst");
    chk("tp_mr_valid", 32'(bus.id_valid), 32'h0);
    chk("tp_mr_pc", bus.id_pc, 32'h0);
    chk("tp_mr_inst", bus.id_inst, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/id_operand_front.md
# id_operand_front

Parametrised successor to the decode stage's front end. It owns the IF→ID pipeline register and an instruction-hold buffer that keeps the fetched word stable across ID stalls. It also provides an N-source forwarding network with register-zero protection and a load-use interlock. It sits between IF/inst-SRAM and the ID decoder/branch unit, which consume its resolved operands.

## Interface
- NUM_FWD, 2, number of forwarding producer stages; index 0 is the youngest and has the highest priority.
- STALL_W, 6, width of the stall bus.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- stall  in  STALL_W  pipeline stall bus; bit 1 = IF stop, bit 2 = ID stop (1 = stop).
- flush  in  1  squash the ID register.
- if_ce  in  1  IF slot valid.
- if_pc  in  32  IF PC.
- inst_sram_rdata  in  32  synchronous inst-SRAM read data, aligned with the ID register.
- fwd_we  in  NUM_FWD  producer write enable.
- fwd_waddr  in  5*NUM_FWD  producer destination; stage i occupies bits [5i+4:5i].
- fwd_wdata  in  32*NUM_FWD  producer result; stage i occupies bits [32i+31:32i].
- fwd_is_load  in  NUM_FWD  producer result not yet available (load in flight).
- rf_raddr1 / rf_raddr2  out  5  regfile read addresses; equal to id_inst[25:21] and id_inst[20:16].
- rf_rdata1 / rf_rdata2  in  32  regfile read data (combinational).
- id_valid  out  1  ID slot holds a live instruction.
- id_pc  out  32  ID PC.
- id_inst  out  32  ID instruction; 0 (nop) when id_valid=0.
- src1 / src2  out  32  resolved rs / rt values.
- stallreq  out  1  load-use interlock request.
- stall_cycles  out  32  present only with ID_PERF_CNT_EN.

## Operation
Register update on posedge clk. The conditions are evaluated in this priority order:
1. rst (async): id_valid=0, id_pc=0, hold_valid=0, hold_inst=0, stall_cycles=0.
2. flush: id_valid←0, hold_valid←0; id_pc is unchanged.
3. stall[1]=1 and stall[2]=0: bubble; id_valid←0, hold_valid←0.
4. stall[1]=0: id_valid←if_ce, id_pc←if_pc, hold_valid←0.
5. Otherwise (ID held): id_valid and id_pc are kept. If hold_valid=0, then hold_inst←inst_sram_rdata and hold_valid←1. A hold already in progress is never overwritten.

Instruction selection:
- id_inst = id_valid ? (hold_valid ? hold_inst : inst_sram_rdata) : 0.

Forwarding, applied per operand with address a (rs for src1, rt for src2):
- If a=0, the result is 0. No forwarding and no interlock apply to register zero.
- Otherwise the result is fwd_wdata of the lowest index i with fwd_we[i]=1 and fwd_waddr[i]=a.
- If no stage matches, the result is rf_rdata.
- When id_valid=0, src1 and src2 are still computed but are don't-care.

Interlock:
- stallreq=1 when id_valid=1 and, for rs or rt, the selected matching stage has fwd_is_load=1.
- An older load shadowed by a younger non-load match does not stall.
- The interlock is conservative: rs and rt are checked whether or not the opcode reads them.

## Timing
- Forwarding, src, stallreq and rf_raddr are combinational from the registered state plus same-cycle inputs; there is no added latency.
- The ID register advances one instruction per unstalled cycle.
- Held instruction: the first held cycle still presents inst_sram_rdata and captures it at the end of that cycle. From the second held cycle, hold_inst is presented.
- Releasing a stall (rule 4) clears hold_valid in the same edge that loads the next instruction.
- Flush during a hold drops the hold. The next cycle shows id_inst=0.
- Reset mid-hold: all state clears immediately (asynchronous).

## Configuration
- ID_PERF_CNT_EN defined: the stall_cycles port exists. It increments each cycle with id_valid&stallreq, saturates at 32'hFFFF_FFFF, and clears only on rst.
- ID_PERF_CNT_EN undefined: neither the port nor the counter logic exists. All other behaviour is identical.

## Structure
- Shared package id_pkg holds:
  - REG_ZERO;
  - STALL_IF_BIT=1 and STALL_ID_BIT=2;
  - instruction field bit positions (RS_HI/LO, RT_HI/LO);
  - NOP_INST=32'h0.
- Sub-module id_fwd_mux (parameter NUM_FWD) resolves one operand. It takes the address, producer buses and regfile data, and outputs the value and a load_hit flag. It is instantiated twice, once for rs and once for rt.

## Test plan
- Reset, then if_ce=1, if_pc=0xBFC00000, stall=0 → next cycle id_valid=1, id_pc=0xBFC00000, id_inst=rdata.
- stall=6'b000110 for 3 cycles, with rdata changing 0x1111→0x2222→0x3333 → id_inst stays 0x1111 throughout. After release, the next word loads.
- rs=5: fwd0 (we=1, addr=5, data=0xA) and fwd1 (we=1, addr=5, data=0xB) → src1=0xA. Drop fwd0 → src1=0xB. Drop both → src1=rf_rdata1.
- rt=0 with fwd0 (we=1, addr=0, data=0xDEAD, is_load=1) → src2=0, stallreq=0.
- rs=7 with fwd0 (addr=7, is_load=1) → stallreq=1. Add fwd0 non-load addr=7 and fwd1 load addr=7 → stallreq=0. With ID_PERF_CNT_EN, 4 stalled cycles give stall_cycles=4.
- flush asserted during an ID hold → next cycle id_valid=0, id_inst=0, hold cleared. rst asserted mid-cycle → outputs zero immediately.
